fft_input_packer: RTL and testbench
===================================

// Module: fft_input_packer
// PURPOSE
//  Upstream feeder of the 512-pt FFT stage-0 pipeline (mod0_0..cbfp0). Accepts one complex
//  9-bit sample per cycle from the ADC-side stream and packs 16 consecutive samples into
//  one 16-lane vector (din_R/din_Q), pulsing valid_out once per vector. Tracks 32-vector
//  frame alignment, flags frame-length errors and zero-pads short frames.
// PARAMETERS
//  DATA_WIDTH   9    sample width, signed two's complement (I and Q each)
//  NUM_LANES    16   samples per output vector
//  FRAME_VECS   32   vectors per frame (NUM_LANES*FRAME_VECS = 512-pt frame)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 synchronous, active-high reset
//  in_valid     in   1                 in_R/in_Q/in_last valid this cycle
//  in_R         in   DATA_WIDTH        signed real sample
//  in_Q         in   DATA_WIDTH        signed imag sample
//  in_last      in   1                 marks final sample of a frame
//  dout_R       out  DATA_WIDTH x16    packed real vector, lane 0 = earliest sample
//  dout_Q       out  DATA_WIDTH x16    packed imag vector
//  valid_out    out  1                 1-cycle strobe: dout_R/dout_Q hold a new vector
//  frame_start  out  1                 with valid_out on vector 0 of a frame
//  frame_end    out  1                 with valid_out on final vector of a frame
//  err_frame    out  1                 sticky: frame length != 512; cleared only by rst
// BEHAVIOUR
//  Reset (rst=1 at clk edge): lane_cnt=0, vec_cnt=0, lane buffer zeroed, dout_R/dout_Q=0,
//   valid_out/frame_start/frame_end/err_frame=0. Reset mid-frame discards partial data.
//  Lane fill: on in_valid, sample written to buffer lane lane_cnt; lane_cnt++ (4-bit wrap).
//   in_valid=0 cycles are bubbles: nothing changes, valid_out=0.
//  Emit: when sample accepted at lane_cnt==15, the next clk edge loads buffer(lanes 0..14)
//   + current sample (lane 15) into dout_R/dout_Q and raises valid_out for exactly 1 cycle.
//   Latency: last sample of vector -> valid_out = 1 cycle. dout holds value until next emit.
//  Back-to-back: continuous in_valid gives valid_out every 16th cycle; no stall, no ready
//   (downstream always accepts).
//  Frame tracking: vec_cnt 0..FRAME_VECS-1 increments per emit, wraps to 0 after 31.
//   frame_start = valid_out & (emitted vec_cnt==0); frame_end = valid_out & (vec_cnt==31).
//  in_last exactly at sample 511 (vec 31, lane 15): normal emit, frame_end=1, counters->0.
//  Early in_last (any other position): current sample stored, remaining lanes zero-filled,
//   vector emitted next cycle with frame_end=1; err_frame<=1; lane_cnt, vec_cnt -> 0.
//   If in_last on lane 15 of vec<31: normal emit with frame_end=1, err_frame<=1, counters->0.
//  Missing in_last at sample 511: vector emitted, frame_end=1, err_frame<=1, counters wrap.
//  frame_start and frame_end both 1 only for a 1-vector frame (in_last within vector 0).
//  No arithmetic: samples pass bit-exact; zero-pad lanes are 0 in both R and Q.
//  Single FSM-free datapath: state is {lane_cnt[3:0], vec_cnt[4:0], err_frame}.
// TESTING
//  1 Reset then 512 continuous samples R=k-256, Q=255-k, in_last at k=511 -> 32 valid_out
//    pulses 16 cycles apart, vec0 lane0 R=-256, vec31 lane15 R=255, frame_start on 1st,
//    frame_end on 32nd, err_frame=0.
//  2 Same frame with random in_valid bubbles (50%) -> identical vectors, valid_out only
//    one cycle after each 16th accepted sample.
//  3 in_last on sample 20 (vec1 lane4) -> 2nd vector lanes 0..4 data, lanes 5..15 = 0,
//    frame_end=1, err_frame=1; next sample lands in vec0 lane0 with frame_start=1.
//  4 512 samples without in_last -> frame_end on 32nd vector, err_frame=1, next vector
//    frame_start=1.
//  5 rst asserted after 100 samples, then full 512 frame -> first emitted vector contains
//    post-reset samples 0..15 only, err_frame=0, outputs 0 during reset cycle.
//  6 Two back-to-back frames, no gap -> 64 pulses, frame_end(31) then frame_start(32)
//    on consecutive emits, vectors of frame 2 bit-exact.

Source files
------------

// File: rtl/fft_input_packer.sv
// Packs a stream of complex 9-bit samples into 16-lane vectors for the 512-pt FFT
// stage-0 pipeline, tracking 32-vector frame alignment and frame-length errors.
module fft_input_packer #(
    parameter int DATA_WIDTH = 9,
    parameter int NUM_LANES  = 16,
    parameter int FRAME_VECS = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic signed [DATA_WIDTH-1:0]           in_R,
    input  logic signed [DATA_WIDTH-1:0]           in_Q,
    input  logic                                   in_last,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   dout_R,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]   dout_Q,
    output logic                                   valid_out,
    output logic                                   frame_start,
    output logic                                   frame_end,
    output logic                                   err_frame
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int VEC_W  = $clog2(FRAME_VECS);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(FRAME_VECS - 1);

    logic [LANE_W-1:0]                  lane_cnt;
    logic [VEC_W-1:0]                   vec_cnt;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] hold_R;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] hold_Q;

    logic                               lane_full_p0;
    logic                               vec_full_p0;
    logic                               emit_p0;
    logic                               frame_done_p0;
    logic                               len_err_p0;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_R_p0;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vec_Q_p0;

    // Lanes already filled come from the hold buffer, the current sample goes to
    // lane_cnt, and anything above it is zero padding for a short final vector.
    function automatic logic [DATA_WIDTH-1:0] pack_lane(
        input int                     lane,
        input logic [LANE_W-1:0]      fill,
        input logic [DATA_WIDTH-1:0]  held,
        input logic [DATA_WIDTH-1:0]  cur
    );
        if (LANE_W'(lane) == fill)
            return cur;
        else if (LANE_W'(lane) < fill)
            return held;
        else
            return '0;
    endfunction

    // Stage p0: accept decision and vector assembly from the incoming sample
    always_comb begin
        lane_full_p0  = (lane_cnt == LAST_LANE);
        vec_full_p0   = (vec_cnt == LAST_VEC);
        emit_p0       = in_valid & (lane_full_p0 | in_last);
        frame_done_p0 = emit_p0 & (vec_full_p0 | in_last);
        len_err_p0    = 1'b0;
        if (in_valid) begin
            if (in_last)
                len_err_p0 = ~(lane_full_p0 & vec_full_p0);
            else
                len_err_p0 = lane_full_p0 & vec_full_p0;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            vec_R_p0[i] = pack_lane(i, lane_cnt, hold_R[i], in_R);
            vec_Q_p0[i] = pack_lane(i, lane_cnt, hold_Q[i], in_Q);
        end
    end

    // Stage p1: counters, hold buffer and registered vector outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt    <= '0;
            vec_cnt     <= '0;
            hold_R      <= '0;
            hold_Q      <= '0;
            dout_R      <= '0;
            dout_Q      <= '0;
            valid_out   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            valid_out   <= emit_p0;
            frame_start <= emit_p0 & (vec_cnt == '0);
            frame_end   <= frame_done_p0;
            if (len_err_p0)
                err_frame <= 1'b1;
            if (in_valid) begin
                hold_R[lane_cnt] <= in_R;
                hold_Q[lane_cnt] <= in_Q;
                lane_cnt         <= emit_p0 ? '0 : lane_cnt + LANE_W'(1);
            end
            if (emit_p0) begin
                dout_R  <= vec_R_p0;
                dout_Q  <= vec_Q_p0;
                vec_cnt <= frame_done_p0 ? '0 : vec_cnt + VEC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fft_input_packer.sv
// Bench for fft_input_packer: table of frame scenarios driven through a sample
// model whose expected vectors are queued and matched against valid_out pulses.
module tb_fft_input_packer;

    localparam int DW = 9;
    localparam int NL = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_last;
    logic signed [DW-1:0]    in_R;
    logic signed [DW-1:0]    in_Q;
    logic [NL-1:0][DW-1:0]   dout_R;
    logic [NL-1:0][DW-1:0]   dout_Q;
    logic                    valid_out;
    logic                    frame_start;
    logic                    frame_end;
    logic                    err_frame;

    fft_input_packer #(.DATA_WIDTH(DW), .NUM_LANES(NL), .FRAME_VECS(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_R(in_R), .in_Q(in_Q),
        .in_last(in_last), .dout_R(dout_R), .dout_Q(dout_Q), .valid_out(valid_out),
        .frame_start(frame_start), .frame_end(frame_end), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NL-1:0][DW-1:0] r;
        logic [NL-1:0][DW-1:0] q;
        logic fs;
        logic fe;
        int   cyc;
    } vec_t;

    vec_t sb[$];
    vec_t mon_e;

    logic [NL-1:0][DW-1:0] m_r;
    logic [NL-1:0][DW-1:0] m_q;
    int m_lane;
    int m_vec;

    task automatic chk(input string name, input logic [NL*DW-1:0] act, input logic [NL*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; valid samples also update the reference model.
    task automatic drive(input bit v, input int k, input bit last);
        vec_t e;
        in_valid = v;
        if (v) begin
            in_last = last;
            in_R    = DW'(k % 512 - 256);
            in_Q    = DW'(255 - k % 512);
            m_r[m_lane] = in_R;
            m_q[m_lane] = in_Q;
            if (m_lane == NL - 1 || last) begin
                for (int i = 0; i < NL; i++) begin
                    e.r[i] = (i <= m_lane) ? m_r[i] : '0;
                    e.q[i] = (i <= m_lane) ? m_q[i] : '0;
                end
                e.fs  = (m_vec == 0);
                e.fe  = last || (m_vec == 31);
                e.cyc = cyc + 1;
                sb.push_back(e);
                m_vec  = (last || m_vec == 31) ? 0 : m_vec + 1;
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end else begin
            in_last = 1'($urandom);
            in_R    = DW'($urandom);
            in_Q    = DW'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_R = '0;
        in_Q = '0;
        @(posedge clk);
        #1;
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_err_frame", err_frame, 0);
        chk("rst_dout_R", dout_R, 0);
        chk("rst_dout_Q", dout_Q, 0);
        rst = 1'b0;
        m_lane = 0;
        m_vec = 0;
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            pulse_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid_out=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("vec_R", dout_R, mon_e.r);
                chk("vec_Q", dout_Q, mon_e.q);
                chk("frame_start", frame_start, mon_e.fs);
                chk("frame_end", frame_end, mon_e.fe);
                chk("latency_cycle", cyc, mon_e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_valid: got no valid_out by cycle %0d expected at %0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    typedef struct {
        string name;
        bit    pre_rst;
        int    nsamp;
        int    last_mod;
        int    bubble;
        bit    exp_err;
        int    exp_pulses;
    } tc_t;

    tc_t tab[9];

    initial begin
        tab[0] = '{"full_frame",    1'b1,  512, 512,  0, 1'b0, 32};
        tab[1] = '{"bubbles",       1'b1,  512, 512, 50, 1'b0, 32};
        tab[2] = '{"early_last",    1'b1,   21,  21,  0, 1'b1,  2};
        tab[3] = '{"after_early",   1'b0,   16,   0,  0, 1'b1,  1};
        tab[4] = '{"no_last",       1'b1,  512,   0,  0, 1'b1, 32};
        tab[5] = '{"after_no_last", 1'b0,   16,   0,  0, 1'b1,  1};
        tab[6] = '{"two_frames",    1'b1, 1024, 512,  0, 1'b0, 64};
        tab[7] = '{"one_vec_frame", 1'b1,    8,   8,  0, 1'b1,  1};
        tab[8] = '{"last_lane15",   1'b1,   32,  32,  0, 1'b1,  2};

        m_r = '0;
        m_q = '0;
        m_lane = 0;
        m_vec = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_R = '0;
        in_Q = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int t = 0; t < 9; t++) begin
            if (tab[t].pre_rst)
                do_reset();
            pulse_cnt = 0;
            for (int k = 0; k < tab[t].nsamp; k++) begin
                while (tab[t].bubble > 0 && $urandom_range(99) < tab[t].bubble)
                    drive(1'b0, 0, 1'b0);
                drive(1'b1, k, tab[t].last_mod != 0 && (k % tab[t].last_mod) == tab[t].last_mod - 1);
            end
            repeat (3) drive(1'b0, 0, 1'b0);
            chk({tab[t].name, "_err_frame"}, err_frame, tab[t].exp_err);
            chk({tab[t].name, "_pulses"}, pulse_cnt, tab[t].exp_pulses);
            chk({tab[t].name, "_drained"}, sb.size(), 0);
        end

        // Reset in the middle of a frame, then a clean full frame
        do_reset();
        for (int k = 0; k < 100; k++)
            drive(1'b1, k, 1'b0);
        do_reset();
        pulse_cnt = 0;
        for (int k = 0; k < 512; k++)
            drive(1'b1, k, k == 511);
        repeat (3) drive(1'b0, 0, 1'b0);
        chk("midrst_err_frame", err_frame, 0);
        chk("midrst_pulses", pulse_cnt, 32);
        chk("midrst_drained", sb.size(), 0);
        chk("hold_lane15_R", dout_R[15], 9'h0ff);
        chk("hold_lane15_Q", dout_Q[15], 9'h100);
        chk("hold_lane0_R", dout_R[0], 9'h0f0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
